// File: rtl/pe_disp_pkg.sv
// pe_disp_pkg: shared constants and types for the PE-array dispatcher.
//   LANES/DW/CW/LEN_W : default lane count, operand, result and length widths
//   LANE_W            : width of a lane index
//   disp_state_t      : dispatcher FSM encoding (IDLE=0, FEED=1, DRAIN=2, DONE=3)
package pe_disp_pkg;

  localparam int LANES  = 8;
  localparam int DW     = 8;
  localparam int CW     = 32;
  localparam int LEN_W  = 16;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } disp_state_t;

endpackage

// File: rtl/pe_dispatcher_if.sv
// pe_dispatcher_if: lane bus between the dispatcher and the PE array.
//   pe_a, pe_b   : operand pair broadcast to the array
//   pe_in_valid  : one-hot lane select for the operand pair
//   pe_store     : last-pair marker, subset of pe_in_valid
//   pe_c         : packed lane results, lane i at [i*CW +: CW]
//   pe_out_valid : per-lane result held until acknowledged
//   pe_out_resp  : per-lane one-cycle acknowledge
// Modports: master (dispatcher), slave (PE array).
interface pe_dispatcher_if;
  import pe_disp_pkg::*;

  logic [DW-1:0]       pe_a;
  logic [DW-1:0]       pe_b;
  logic [LANES-1:0]    pe_in_valid;
  logic [LANES-1:0]    pe_store;
  logic [LANES*CW-1:0] pe_c;
  logic [LANES-1:0]    pe_out_valid;
  logic [LANES-1:0]    pe_out_resp;

  modport master (
    output pe_a, pe_b, pe_in_valid, pe_store, pe_out_resp,
    input  pe_c, pe_out_valid
  );

  modport slave (
    input  pe_a, pe_b, pe_in_valid, pe_store, pe_out_resp,
    output pe_c, pe_out_valid
  );

endinterface

// File: rtl/pe_result_drain.sv
// pe_result_drain: collects lane results in lane order and presents them as a
// valid/ready stream, pulsing pe_out_resp for the lane once it is accepted.
//   clk, rst      : clock, asynchronous active-low reset
//   en            : high while the dispatcher is in DRAIN
//   pe_c          : packed lane results
//   pe_out_valid  : per-lane result-held flags
//   pe_out_resp   : one-cycle acknowledge to the accepted lane
//   m_valid/m_ready/m_data/m_lane/m_last : result stream
//   last_accept   : lane LANES-1 accepted this cycle
// Build option PE_DISP_RELU_EN: negative results are clamped to zero.
module pe_result_drain
  import pe_disp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [LANES*CW-1:0] pe_c,
  input  logic [LANES-1:0]    pe_out_valid,
  output logic [LANES-1:0]    pe_out_resp,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CW-1:0]       m_data,
  output logic [LANE_W-1:0]   m_lane,
  output logic                m_last,
  output logic                last_accept
);

  localparam logic [LANES-1:0]  ONE_HOT0  = LANES'(1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [LANE_W-1:0] cur;
  logic [CW-1:0]     slice;
  logic [CW-1:0]     result;

  assign slice = pe_c[cur*CW +: CW];

`ifdef PE_DISP_RELU_EN
  assign result = slice[CW-1] ? '0 : slice;
`else
  assign result = slice;
`endif

  assign last_accept = en && m_valid && m_ready && m_last;

  // Only the lane under the cursor is ever sampled; after an accept the
  // cursor moves on, so the acknowledged lane is not re-read while the array
  // is still dropping its valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur         <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_lane      <= '0;
      m_last      <= 1'b0;
      pe_out_resp <= '0;
    end else if (!en) begin
      cur         <= '0;
      m_valid     <= 1'b0;
      pe_out_resp <= '0;
    end else begin
      pe_out_resp <= '0;
      if (m_valid) begin
        if (m_ready) begin
          m_valid     <= 1'b0;
          pe_out_resp <= ONE_HOT0 << cur;
          cur         <= cur + LANE_W'(1);
        end
      end else if (pe_out_valid[cur]) begin
        m_valid <= 1'b1;
        m_data  <= result;
        m_lane  <= cur;
        m_last  <= (cur == LAST_LANE);
      end
    end
  end

endmodule

// File: rtl/pe_dispatcher.sv
// pe_dispatcher: feeds operand pairs to an 8-lane PE array (interleaved lane
// order, STORE on each lane's last pair), then drains the lane results in
// order onto a valid/ready stream.
//   clk, rst       : clock, asynchronous active-low reset
//   start, cfg_len : round start and pairs-per-lane K (ignored when K == 0)
//   busy, done     : round in progress / one-cycle completion pulse
//   s_valid, s_ready, s_a, s_b : operand pair input stream
//   pe             : lane bus to the PE array (pe_dispatcher_if.master)
//   m_valid, m_ready, m_data, m_lane, m_last : result stream
// Build option PE_DISP_RELU_EN (in pe_result_drain): clamp negative results.
module pe_dispatcher
  import pe_disp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  output logic                 busy,
  output logic                 done,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DW-1:0]        s_a,
  input  logic [DW-1:0]        s_b,
  pe_dispatcher_if.master      pe,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CW-1:0]        m_data,
  output logic [LANE_W-1:0]    m_lane,
  output logic                 m_last
);

  localparam logic [LANES-1:0]  ONE_HOT0  = LANES'(1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  disp_state_t       state;
  logic [LEN_W-1:0]  k_len;
  logic [LANE_W-1:0] lane;
  logic [LEN_W-1:0]  elem;
  logic              last_accept;
  logic              last_elem;

  assign last_elem = (elem == k_len - LEN_W'(1));

  pe_result_drain u_drain (
    .clk          (clk),
    .rst          (rst),
    .en           (state == DRAIN),
    .pe_c         (pe.pe_c),
    .pe_out_valid (pe.pe_out_valid),
    .pe_out_resp  (pe.pe_out_resp),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_lane       (m_lane),
    .m_last       (m_last),
    .last_accept  (last_accept)
  );

  // Lane select and store are single-cycle strobes; they default to zero and
  // are only raised in FEED for a pair actually presented on s_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      k_len          <= '0;
      lane           <= '0;
      elem           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      s_ready        <= 1'b0;
      pe.pe_a        <= '0;
      pe.pe_b        <= '0;
      pe.pe_in_valid <= '0;
      pe.pe_store    <= '0;
    end else begin
      done           <= 1'b0;
      pe.pe_in_valid <= '0;
      pe.pe_store    <= '0;
      case (state)
        IDLE: begin
          if (start && cfg_len != '0) begin
            k_len   <= cfg_len;
            lane    <= '0;
            elem    <= '0;
            busy    <= 1'b1;
            s_ready <= 1'b1;
            state   <= FEED;
          end
        end
        FEED: begin
          if (s_valid) begin
            pe.pe_a        <= s_a;
            pe.pe_b        <= s_b;
            pe.pe_in_valid <= ONE_HOT0 << lane;
            if (last_elem) pe.pe_store <= ONE_HOT0 << lane;
            if (lane == LAST_LANE) begin
              lane <= '0;
              if (last_elem) begin
                s_ready <= 1'b0;
                state   <= DRAIN;
              end else begin
                elem <= elem + LEN_W'(1);
              end
            end else begin
              lane <= lane + LANE_W'(1);
            end
          end
        end
        DRAIN: begin
          if (last_accept) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_dispatcher.sv
// tb_pe_dispatcher: scoreboard bench for pe_dispatcher with a behavioural
// multiply-accumulate PE array model.
module tb_pe_dispatcher;
  import pe_disp_pkg::*;

  localparam logic [LANES-1:0] ONE_HOT0 = LANES'(1);

  typedef struct {
    logic [LANES-1:0] iv;
    logic [LANES-1:0] st;
    logic [DW-1:0]    a;
    logic [DW-1:0]    b;
  } feed_t;

  typedef struct {
    logic [CW-1:0]     data;
    logic [LANE_W-1:0] lane;
    logic              last;
  } res_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic              busy, done;
  logic              s_valid, s_ready;
  logic [DW-1:0]     s_a, s_b;
  logic              m_valid, m_ready;
  logic [CW-1:0]     m_data;
  logic [LANE_W-1:0] m_lane;
  logic              m_last;

  pe_dispatcher_if pe_if ();

  pe_dispatcher dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cfg_len (cfg_len),
    .busy    (busy),
    .done    (done),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_b     (s_b),
    .pe      (pe_if),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_lane  (m_lane),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int feed_issued = 0;
  int done_seen = 0;
  bit bp_en = 0;
  int bp_cnt = 0;

  feed_t exp_feed[$];
  res_t  exp_res[$];

  // Behavioural PE array: signed MAC per lane, result held until acknowledged.
  logic signed [CW-1:0] acc [LANES];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
      pe_if.pe_out_valid <= '0;
      pe_if.pe_c         <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (pe_if.pe_out_resp[i]) pe_if.pe_out_valid[i] <= 1'b0;
        if (pe_if.pe_in_valid[i]) begin
          if (pe_if.pe_store[i]) begin
            pe_if.pe_c[i*CW +: CW] <= acc[i] + $signed(pe_if.pe_a) * $signed(pe_if.pe_b);
            pe_if.pe_out_valid[i]  <= 1'b1;
            acc[i]                 <= '0;
          end else begin
            acc[i] <= acc[i] + $signed(pe_if.pe_a) * $signed(pe_if.pe_b);
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_missing(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got no expected entry, expected one queued at %0t", name, $time);
  endtask

  // Downstream ready: optionally stalls lane 3 for five cycles.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_en && m_valid && m_lane == 3 && bp_cnt < 5) begin
        m_ready = 1'b0;
        bp_cnt++;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Monitor: pops scoreboards and checks handshake timing every cycle.
  feed_t             f;
  res_t              r;
  bit                prev_fire, prev_acc, prev_last, prev_stall;
  logic [LANE_W-1:0] prev_lane;
  logic [CW-1:0]     hold_data;
  logic [LANE_W-1:0] hold_lane;
  logic              hold_last;

  always @(negedge clk) begin
    if (!rst) begin
      prev_fire  = 0;
      prev_acc   = 0;
      prev_last  = 0;
      prev_stall = 0;
    end else begin
      if (prev_fire) begin
        if (exp_feed.size() == 0) report_missing("feed_extra");
        else begin
          f = exp_feed.pop_front();
          feed_issued++;
          check_output("feed_sel", pe_if.pe_in_valid, f.iv);
          check_output("feed_store", pe_if.pe_store, f.st);
          check_output("feed_ops", {pe_if.pe_a, pe_if.pe_b}, {f.a, f.b});
        end
      end else begin
        check_output("feed_idle", {pe_if.pe_in_valid, pe_if.pe_store}, '0);
      end
      if (prev_acc) check_output("resp_pulse", {pe_if.pe_out_resp, m_valid}, {ONE_HOT0 << prev_lane, 1'b0});
      else          check_output("resp_idle", pe_if.pe_out_resp, '0);
      check_output("done_pulse", done, prev_acc && prev_last);
      if (prev_stall) check_output("stall_hold", {m_valid, m_data, m_lane, m_last},
                                   {1'b1, hold_data, hold_lane, hold_last});
      if (m_valid && m_ready) begin
        if (exp_res.size() == 0) report_missing("result_extra");
        else begin
          r = exp_res.pop_front();
          check_output("result", {m_data, m_lane, m_last}, {r.data, r.lane, r.last});
        end
      end
      if (done) done_seen++;
      prev_fire  = s_valid && s_ready;
      prev_acc   = m_valid && m_ready;
      prev_lane  = m_lane;
      prev_last  = m_last;
      prev_stall = m_valid && !m_ready;
      hold_data  = m_data;
      hold_lane  = m_lane;
      hold_last  = m_last;
    end
  end

  function automatic logic [DW-1:0] op_a(input int mode, input int l);
    if (mode == 2 && l == 2) return 8'hF9;
    if (mode == 2 && l == 5) return 8'd9;
    return DW'(l + 1);
  endfunction

  function automatic logic [DW-1:0] op_b(input int mode, input int e);
    if (mode == 0) return 8'd2;
    if (mode == 1) return DW'(e + 1);
    return 8'd1;
  endfunction

  task automatic drive_pair(input bit valid, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input int l, input bit store);
    feed_t e;
    s_valid = valid;
    s_a     = a;
    s_b     = b;
    if (valid) begin
      e.iv = ONE_HOT0 << l;
      e.st = store ? (ONE_HOT0 << l) : '0;
      e.a  = a;
      e.b  = b;
      exp_feed.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // Starts a round of K pairs per lane and feeds it; optional gap cycles and
  // an extra start pulse in the middle of the feed.
  task automatic apply_stimulus(input int k, input bit gap, input int mode, input bit inject_start);
    cfg_len = LEN_W'(k);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    cfg_len = '0;
    check_output("start_busy", {busy, s_ready}, 2'b11);
    for (int e = 0; e < k; e++) begin
      for (int l = 0; l < LANES; l++) begin
        if (inject_start && e == 1 && l == 0) begin
          start   = 1'b1;
          cfg_len = LEN_W'(1);
        end
        drive_pair(1'b1, op_a(mode, l), op_b(mode, e), l, e == k - 1);
        start   = 1'b0;
        cfg_len = '0;
        if (gap) drive_pair(1'b0, 8'h00, 8'h00, l, 1'b0);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic push_result(input logic [CW-1:0] data, input int l);
    res_t e;
    e.data = data;
    e.lane = LANE_W'(l);
    e.last = (l == LANES - 1);
    exp_res.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check_output(name, seen, 1'b1);
    check_output({name, "_busy"}, busy, 1'b0);
    @(posedge clk); #1;
    check_output({name, "_queues"}, {32'(exp_feed.size()), 32'(exp_res.size())}, '0);
  endtask

  int d0;

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    cfg_len = '0;
    s_valid = 1'b0;
    s_a     = '0;
    s_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ctrl", {busy, done, s_ready, m_valid, m_lane, m_last}, '0);
    check_output("reset_pe", {pe_if.pe_a, pe_if.pe_b, pe_if.pe_in_valid, pe_if.pe_store, pe_if.pe_out_resp}, '0);
    check_output("reset_data", m_data, '0);
    rst = 1'b1;
    @(posedge clk); #1;

    // start with zero length is ignored
    start = 1'b1;
    cfg_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("zero_len_start", {busy, s_ready}, 2'b00);
    @(posedge clk); #1;

    // K=2, all lanes full rate
    d0 = done_seen;
    for (int l = 0; l < LANES; l++) push_result(CW'(4 * (l + 1)), l);
    apply_stimulus(2, 1'b0, 0, 1'b0);
    wait_done("k2_done");
    check_output("k2_done_count", done_seen - d0, 1);

    // K=3 with s_valid gaps and an ignored start during FEED
    d0 = done_seen;
    feed_issued = 0;
    for (int l = 0; l < LANES; l++) push_result(CW'(6 * (l + 1)), l);
    apply_stimulus(3, 1'b1, 1, 1'b1);
    wait_done("gap_done");
    check_output("gap_pairs", feed_issued, 24);
    check_output("gap_done_count", done_seen - d0, 1);

    // backpressure on lane 3
    bp_en  = 1;
    bp_cnt = 0;
    for (int l = 0; l < LANES; l++) push_result(CW'(l + 1), l);
    apply_stimulus(1, 1'b0, 3, 1'b0);
    wait_done("bp_done");
    check_output("bp_stall_cycles", bp_cnt, 5);
    bp_en = 0;

    // negative and positive results
    for (int l = 0; l < LANES; l++) begin
`ifdef PE_DISP_RELU_EN
      if (l == 2) push_result(32'h0000_0000, l);
`else
      if (l == 2) push_result(32'hFFFF_FFF9, l);
`endif
      else if (l == 5) push_result(32'd9, l);
      else push_result(CW'(l + 1), l);
    end
    apply_stimulus(1, 1'b0, 2, 1'b0);
    wait_done("relu_done");

    // reset in the middle of the drain, then a clean round
    for (int l = 0; l < LANES; l++) push_result(CW'(l + 1), l);
    apply_stimulus(1, 1'b0, 3, 1'b0);
    begin
      bit hit = 0;
      for (int i = 0; i < 100; i++) begin
        if (m_valid && m_lane == 4) begin
          hit = 1;
          break;
        end
        @(posedge clk); #1;
      end
      check_output("mid_drain_lane4", hit, 1'b1);
    end
    rst = 1'b0;
    #1;
    check_output("midrst_ctrl", {busy, done, s_ready, m_valid, m_lane, m_last}, '0);
    check_output("midrst_pe", {pe_if.pe_a, pe_if.pe_b, pe_if.pe_in_valid, pe_if.pe_store, pe_if.pe_out_resp}, '0);
    check_output("midrst_data", m_data, '0);
    exp_res.delete();
    exp_feed.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    d0 = done_seen;
    for (int l = 0; l < LANES; l++) push_result(CW'(l + 1), l);
    apply_stimulus(1, 1'b0, 3, 1'b0);
    wait_done("post_rst_done");
    check_output("post_rst_done_count", done_seen - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_dispatcher.md
# pe_dispatcher

Initiator side of the PE-array lane protocol. Feeds an 8-lane PE array with operand pairs for one dot-product round: one-hot lane select, STORE marking each lane's last pair. It then collects the eight 32-bit results in lane order through the OUT_VALID/OUT_RESP acknowledge and emits them as a valid/ready result stream. It sits between the operand fetch path and the PE array in the speech-recognition accelerator.

## Interface
- LANES, 8, number of PE lanes (one-hot select width)
- DW, 8, operand width (A, B)
- CW, 32, per-lane result width, signed two's complement
- LEN_W, 16, width of dot-product length
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- start  in  1  begin a round; sampled only in IDLE
- cfg_len  in  LEN_W  pairs per lane K; latched on accepted start
- busy  out  1  high in FEED/DRAIN
- done  out  1  one-cycle pulse after last result accepted
- s_valid  in  1  operand pair valid
- s_ready  out  1  operand pair accepted when s_valid&&s_ready
- s_a, s_b  in  DW  operand pair
- pe_a, pe_b  out  DW  operands to array
- pe_in_valid  out  LANES  one-hot lane select, zero when idle
- pe_store  out  LANES  last-pair marker, subset of pe_in_valid
- pe_c  in  LANES*CW  lane results, lane i at [i*CW +: CW]
- pe_out_valid  in  LANES  lane i result held until acknowledged
- pe_out_resp  out  LANES  one-cycle acknowledge pulse
- m_valid  out  1  result valid
- m_ready  in  1  downstream accept
- m_data  out  CW  result
- m_lane  out  clog2(LANES)  source lane
- m_last  out  1  high with lane LANES-1 result

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- **IDLE.**
  - start && cfg_len != 0 latches K and goes to FEED.
  - start with cfg_len == 0 is ignored.
- **FEED.**
  - s_ready = 1.
  - Each accepted pair goes to lane cursor l, element counter k, both starting at 0.
  - Lane order is interleaved: element k for lanes 0..LANES-1, then k+1.
  - pe_in_valid = 1<<l; pe_store[l] = (k == K-1).
  - l wraps LANES-1 -> 0 and increments k.
  - The pair at l = LANES-1, k = K-1 moves to DRAIN.
  - No s_valid: pe_in_valid = 0 that cycle.
- **DRAIN.**
  - s_ready = 0.
  - Drain cursor j runs 0..LANES-1.
  - When pe_out_valid[j], register pe_c slice j into m_data, set m_lane = j, m_valid = 1.
  - On m_valid && m_ready: pulse pe_out_resp[j] for exactly one cycle and drop m_valid.
  - Resample only lane j+1; lane j is never re-read.
  - Acceptance of j = LANES-1 goes to DONE.
- **DONE.** done = 1 for one cycle, then IDLE.
- start while busy is ignored.
- A pe_out_valid bit that rises during FEED is held by the array and consumed in DRAIN order.
- m_data/m_lane/m_last stay stable while m_valid && !m_ready.

## Timing
- All outputs are registered.
- Reset value of every output is 0: s_ready, busy, done, pe_a, pe_b, pe_in_valid, pe_store, pe_out_resp, m_valid, m_data, m_lane, m_last. State = IDLE, counters = 0.
- start at edge t: busy and s_ready high from t+1.
- Pair accepted at edge t appears on pe_a/pe_b/pe_in_valid/pe_store during cycle t+1 (1-cycle latency).
- Full-rate feed takes LANES*K cycles.
- pe_out_valid[j] seen at edge t gives m_valid during t+1.
- Accept at edge t gives pe_out_resp[j] during t+1; the next lane's m_valid comes no earlier than t+2.
- Minimum drain is 2 cycles per lane.
- rst asserted mid-round: immediate return to IDLE with all outputs 0. Any partial round is discarded; the array shares the same reset.

## Configuration
- PE_DISP_RELU_EN defined:
  - m_data = (pe_c slice < 0) ? 0 : pe_c slice.
  - Test is the sign bit of the CW-bit value; no added latency.
- Undefined: m_data passes the slice unmodified.
- Handshake timing is identical either way.

## Structure
- Shared package pe_disp_pkg holds:
  - state encoding (IDLE = 0, FEED = 1, DRAIN = 2, DONE = 3)
  - default LANES, DW, CW, LEN_W
  - lane-index width constant
- One natural sub-module, pe_result_drain: drain cursor, result register, ReLU option, OUT_RESP pulse generation.
- Dispatcher top holds the FSM and feed counters.

## Test plan
- **K=2, all lanes.** Lane i gets (i+1, 2) twice, s_valid always high, m_ready high, behavioral PE model.
  - Expected: pe_in_valid walks 0x01..0x80 twice; pe_store only on the second pass.
  - m_data = 4,8,...,32 with m_lane 0..7; m_last only on lane 7; done pulses once.
- **s_valid gaps.** s_valid toggles 1-0-1 with K=3.
  - Expected: pe_in_valid = 0 on gap cycles; exactly 24 pairs issued; lane/element order preserved.
- **Backpressure.** m_ready held low 5 cycles on lane 3.
  - Expected: m_data/m_lane stable; no pe_out_resp[3] until accept, then one pulse; lane 4 not presented before.
- **Ignored starts.** cfg_len=0 start, then start pulsed during FEED.
  - Expected: busy stays low for the first; the second is ignored and K is unchanged.
- **ReLU.** With PE_DISP_RELU_EN, lane 2 result -7 gives m_data = 0, lane 5 result 9 gives 9; without the macro, -7 passes as 0xFFFFFFF9.
- **Reset mid-drain.** rst low during DRAIN at lane 4.
  - Expected: all outputs 0 next cycle; after release a new K=1 round completes normally.
